fetch_unit: RTL and testbench

- Instruction fetch stage of the multi-cycle core, directly upstream of the control/decode stage.
- Owns the program counter and the instruction register.
- Runs a req/ack read handshake to instruction RAM when control requests a fetch.
- Commits the next PC (sequential, branch or jump) when control signals write-back completion.

---
 rtl/fetch_unit.sv | 198 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit                                                   |
// | Description : Instruction fetch stage. Owns the PC and the instruction     |
// |               register, runs the req/ack read handshake to instruction RAM |
// |               and commits sequential / branch / jump PC updates.           |
// | Options     : FETCH_TIMEOUT_EN - fault when RAM ack exceeds TIMEOUT_CYCLES |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic        pc_update_i,
   input  logic        branch_taken_i,
   input  logic        jump_i,
   input  logic [31:0] target_i,
   output logic        req_o,
   output logic [31:0] addr_o,
   input  logic        ack_i,
   input  logic [31:0] data_i,
   output logic [31:0] ir_o,
   output logic        ir_valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        busy_o,
   output logic        fault_o,
   output logic [1:0]  fault_cause_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;

   // Elaboration-time sanity checks on the configuration.
   generate
      if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
         $error("fetch_unit: RESET_PC must be word aligned");
      end
      if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
         $error("fetch_unit: TIMEOUT_CYCLES must be at least 1");
      end
   endgenerate

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] ir_q, ir_d;
   logic        ir_valid_q, ir_valid_d;
   logic        fault_q, fault_d;
   logic [1:0]  cause_q, cause_d;
   logic        pend_q, pend_d;
   logic        pend_take_q, pend_take_d;
   logic [31:0] pend_target_q, pend_target_d;

   logic        upd_valid;
   logic        upd_take;
   logic [31:0] upd_target;
   logic        upd_misalign;
   logic [31:0] upd_pc;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   // Resolve the update to apply in IDLE: a fresh pulse overrides a pending one.
   assign upd_valid    = pc_update_i | pend_q;
   assign upd_take     = pc_update_i ? (jump_i | branch_taken_i) : pend_take_q;
   assign upd_target   = pc_update_i ? target_i : pend_target_q;
   assign upd_misalign = upd_take & (upd_target[1:0] != 2'b00);
   assign upd_pc       = upd_take ? upd_target : pc_plus4;

`ifdef FETCH_TIMEOUT_EN
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
   localparam int         CNT_W         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

   // Count REQ cycles without ack; zero everywhere else so REQ entry starts clean.
   always_comb begin
      to_cnt_d = '0;
      if (state_q == ST_REQ && !ack_i) begin
         to_cnt_d = to_cnt_q + CNT_W'(1);
      end
   end

   // Timeout counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`endif

   // Next-state and datapath decisions for the fetch FSM.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      addr_d        = addr_q;
      ir_d          = ir_q;
      ir_valid_d    = 1'b0;
      fault_d       = fault_q;
      cause_d       = cause_q;
      pend_d        = pend_q;
      pend_take_d   = pend_take_q;
      pend_target_d = pend_target_q;
      case (state_q)
         ST_IDLE: begin
            pend_d = 1'b0;
            if (upd_valid && upd_misalign) begin
               // A bad target kills any fetch requested in the same cycle.
               fault_d = 1'b1;
               cause_d = CAUSE_MISALIGN;
               state_d = ST_FAULT;
            end else begin
               if (upd_valid) begin
                  pc_d = upd_pc;
               end
               if (start_i) begin
                  addr_d  = upd_valid ? upd_pc : pc_q;
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (pc_update_i) begin
               pend_d        = 1'b1;
               pend_take_d   = jump_i | branch_taken_i;
               pend_target_d = target_i;
            end
            if (ack_i) begin
               ir_d       = data_i;
               ir_valid_d = 1'b1;
               state_d    = ST_IDLE;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               fault_d = 1'b1;
               cause_d = CAUSE_TIMEOUT;
               state_d = ST_FAULT;
            end
`endif
         end
         default: begin
            state_d = ST_FAULT;
         end
      endcase
   end

   // State and datapath registers; reset aborts any transaction immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         addr_q        <= RESET_PC;
         ir_q          <= 32'h0;
         ir_valid_q    <= 1'b0;
         fault_q       <= 1'b0;
         cause_q       <= CAUSE_NONE;
         pend_q        <= 1'b0;
         pend_take_q   <= 1'b0;
         pend_target_q <= 32'h0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         addr_q        <= addr_d;
         ir_q          <= ir_d;
         ir_valid_q    <= ir_valid_d;
         fault_q       <= fault_d;
         cause_q       <= cause_d;
         pend_q        <= pend_d;
         pend_take_q   <= pend_take_d;
         pend_target_q <= pend_target_d;
      end
   end

   assign req_o         = (state_q == ST_REQ);
   assign busy_o        = (state_q == ST_REQ);
   assign addr_o        = addr_q;
   assign ir_o          = ir_q;
   assign ir_valid_o    = ir_valid_q;
   assign pc_o          = pc_q;
   assign pc_plus4_o    = pc_plus4;
   assign fault_o       = fault_q;
   assign fault_cause_o = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_unit                                                |
// | Description : Self-checking bench for fetch_unit: RAM responder, ordered   |
// |               fetch scoreboard and a PC/fault reference model.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          TO_CYC = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_i, pc_update_i, branch_taken_i, jump_i;
   logic [31:0] target_i;
   logic        req_o;
   logic [31:0] addr_o;
   logic        ack_i;
   logic [31:0] data_i;
   logic [31:0] ir_o;
   logic        ir_valid_o;
   logic [31:0] pc_o, pc_plus4_o;
   logic        busy_o, fault_o;
   logic [1:0]  fault_cause_o;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .pc_update_i(pc_update_i),
      .branch_taken_i(branch_taken_i), .jump_i(jump_i), .target_i(target_i),
      .req_o(req_o), .addr_o(addr_o), .ack_i(ack_i), .data_i(data_i),
      .ir_o(ir_o), .ir_valid_o(ir_valid_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
      .busy_o(busy_o), .fault_o(fault_o), .fault_cause_o(fault_cause_o)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } fetch_t;

   fetch_t      exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_ir = 32'h0;
   bit          ram_dead = 1'b0;
   bit          noise_en = 1'b0;
   int          lat_force = -1;

   // Reference model state
   logic [31:0] m_pc;
   bit          m_fault;
   logic [1:0]  m_cause;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // RAM responder: random (or forced) latency per request, optional stray acks.
   int   wait_cnt = 0;
   logic prev_req = 1'b0;
   initial begin
      ack_i  = 1'b0;
      data_i = 32'h0;
      forever begin
         @(posedge clk); #1;
         ack_i  = 1'b0;
         data_i = $urandom;
         if (req_o === 1'b1) begin
            if (prev_req !== 1'b1)
               wait_cnt = (lat_force >= 0) ? lat_force : $urandom_range(0, 3);
            if (!ram_dead) begin
               if (wait_cnt == 0) begin
                  ack_i  = 1'b1;
                  data_i = mem_word(addr_o);
               end else begin
                  wait_cnt--;
               end
            end
         end else if (noise_en && $urandom_range(0, 3) == 0) begin
            ack_i = 1'b1;
         end
         prev_req = req_o;
      end
   end

   // Monitor: every ir_valid pulse must match the oldest outstanding fetch.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (ir_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("ir_valid_o spurious", {31'b0, ir_valid_o}, 32'd0);
            end else begin
               fetch_t e;
               e = exp_q.pop_front();
               chk("ir_o data", ir_o, e.data);
               chk("addr_o at completion", addr_o, e.addr);
               last_ir = e.data;
            end
         end else begin
            chk("ir_o hold", ir_o, last_ir);
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      start_i        = 1'b0;
      pc_update_i    = 1'b0;
      jump_i         = 1'b0;
      branch_taken_i = 1'b0;
      target_i       = $urandom;
   endtask

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      int          r;
      r = $urandom_range(0, 15);
      t = $urandom;
      if (r == 0) begin
         if (t[1:0] == 2'b00) t[0] = 1'b1;
      end else if (r == 1) begin
         t = 32'hFFFF_FFFC;
      end else begin
         t[1:0] = 2'b00;
      end
      return t;
   endfunction

   task automatic model_update(input bit take, input logic [31:0] t);
      if (take && t[1:0] != 2'b00) begin
         m_fault = 1'b1;
         m_cause = 2'b01;
      end else begin
         m_pc = take ? t : m_pc + 32'd4;
      end
   endtask

   task automatic check_state();
      chk("pc_o", pc_o, m_pc);
      chk("pc_plus4_o", pc_plus4_o, m_pc + 32'd4);
      chk("fault_o", {31'b0, fault_o}, {31'b0, m_fault});
      chk("fault_cause_o", {30'b0, fault_cause_o}, {30'b0, m_cause});
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      exp_q.delete();
      last_ir = 32'h0;
      m_pc    = RST_PC;
      m_fault = 1'b0;
      m_cause = 2'b00;
      chk("reset pc_o", pc_o, RST_PC);
      chk("reset addr_o", addr_o, RST_PC);
      chk("reset ir_o", ir_o, 32'h0);
      chk("reset req_o", {31'b0, req_o}, 32'd0);
      chk("reset ir_valid_o", {31'b0, ir_valid_o}, 32'd0);
      chk("reset busy_o", {31'b0, busy_o}, 32'd0);
      chk("reset fault_o", {31'b0, fault_o}, 32'd0);
      chk("reset fault_cause_o", {30'b0, fault_cause_o}, 32'd0);
      reset = 1'b0;
      tick();
   endtask

   task automatic do_update(input bit j, input bit b, input logic [31:0] t);
      pc_update_i    = 1'b1;
      jump_i         = j;
      branch_taken_i = b;
      target_i       = t;
      model_update(j | b, t);
      tick();
      idle_inputs();
      check_state();
   endtask

   // mid_mode: 0 none, 1 random start/update noise during REQ, 2 branch to t during REQ
   task automatic do_fetch(input bit with_upd, input bit j, input bit b,
                           input logic [31:0] t, input int mid_mode);
      bit          pend;
      bit          pend_take;
      logic [31:0] pend_t;
      logic [31:0] faddr;
      fetch_t      e;
      int          n;
      start_i = 1'b1;
      if (with_upd) begin
         pc_update_i    = 1'b1;
         jump_i         = j;
         branch_taken_i = b;
         target_i       = t;
         model_update(j | b, t);
      end
      if (m_fault) begin
         tick();
         idle_inputs();
         check_state();
         chk("req_o after faulting start", {31'b0, req_o}, 32'd0);
         return;
      end
      faddr  = m_pc;
      e.addr = faddr;
      e.data = mem_word(faddr);
      exp_q.push_back(e);
      tick();
      idle_inputs();
      chk("addr_o after start", addr_o, faddr);
      pend      = 1'b0;
      pend_take = 1'b0;
      pend_t    = 32'h0;
      n         = 0;
      while (busy_o === 1'b1 && n < 60) begin
         chk("req_o during fetch", {31'b0, req_o}, 32'd1);
         chk("addr_o stable", addr_o, faddr);
         chk("pc_o stable in REQ", pc_o, m_pc);
         if (mid_mode == 1) begin
            start_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
               pc_update_i    = 1'b1;
               jump_i         = 1'($urandom_range(0, 1));
               branch_taken_i = 1'($urandom_range(0, 1));
               target_i       = rand_target();
               pend           = 1'b1;
               pend_take      = jump_i | branch_taken_i;
               pend_t         = target_i;
            end
         end else if (mid_mode == 2 && n == 0) begin
            pc_update_i    = 1'b1;
            branch_taken_i = 1'b1;
            target_i       = t;
            pend           = 1'b1;
            pend_take      = 1'b1;
            pend_t         = t;
         end
         tick();
         idle_inputs();
         n++;
      end
      if (busy_o !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL fetch completion: busy_o %b after %0d cycles, expected 0", busy_o, n);
         do_reset();
         return;
      end
      chk("ir_valid_o at completion", {31'b0, ir_valid_o}, 32'd1);
      check_state();
      if (pend) model_update(pend_take, pend_t);
      tick();
      chk("ir_valid_o one-shot", {31'b0, ir_valid_o}, 32'd0);
      check_state();
   endtask

   task automatic fault_checks();
      start_i     = 1'b1;
      pc_update_i = 1'b1;
      jump_i      = 1'b1;
      target_i    = 32'h0000_0200;
      tick();
      idle_inputs();
      tick();
      chk("req_o in FAULT", {31'b0, req_o}, 32'd0);
      chk("busy_o in FAULT", {31'b0, busy_o}, 32'd0);
      check_state();
      do_reset();
   endtask

   initial begin
      int n;
      reset = 1'b1;
      idle_inputs();
      do_reset();

      // First fetch from reset PC, ack in the cycle req rises
      lat_force = 0;
      do_fetch(1'b0, 1'b0, 1'b0, 32'h0, 0);

      // Sequential wrap from the top of the address space
      do_update(1'b1, 1'b0, 32'hFFFF_FFFC);
      do_update(1'b0, 1'b0, 32'h0000_0123);

      // Jump + branch together with start: fetch uses the new PC
      do_fetch(1'b1, 1'b1, 1'b1, 32'h0000_0100, 0);

      // Branch latched during REQ, applied the cycle after completion
      lat_force = 2;
      do_fetch(1'b0, 1'b0, 1'b0, 32'h0000_0040, 2);

      // Misaligned jump faults; FAULT ignores start/update until reset
      do_update(1'b1, 1'b0, 32'h0000_0102);
      fault_checks();

`ifdef FETCH_TIMEOUT_EN
      // RAM never answers: req held TO_CYC cycles, then timeout fault
      ram_dead = 1'b1;
      start_i  = 1'b1;
      tick();
      idle_inputs();
      for (int i = 0; i < TO_CYC; i++) begin
         chk("req_o before timeout", {31'b0, req_o}, 32'd1);
         tick();
      end
      chk("req_o after timeout", {31'b0, req_o}, 32'd0);
      m_fault = 1'b1;
      m_cause = 2'b10;
      check_state();
      ram_dead = 1'b0;
      fault_checks();
`else
      // RAM stalls for a long time: request simply waits
      ram_dead = 1'b1;
      start_i  = 1'b1;
      begin
         fetch_t e;
         e.addr = m_pc;
         e.data = mem_word(m_pc);
         exp_q.push_back(e);
      end
      tick();
      idle_inputs();
      repeat (20) begin
         chk("req_o while stalled", {31'b0, req_o}, 32'd1);
         chk("fault_o while stalled", {31'b0, fault_o}, 32'd0);
         tick();
      end
      ram_dead = 1'b0;
      n = 0;
      while (busy_o === 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("busy_o after stall release", {31'b0, busy_o}, 32'd0);
      tick();
      check_state();
`endif

      // Asynchronous reset in the middle of a request
      ram_dead = 1'b1;
      do_update(1'b1, 1'b0, 32'h0000_0800);
      start_i = 1'b1;
      tick();
      idle_inputs();
      tick();
      chk("req_o before async reset", {31'b0, req_o}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("req_o right after async reset", {31'b0, req_o}, 32'd0);
      chk("busy_o right after async reset", {31'b0, busy_o}, 32'd0);
      chk("pc_o right after async reset", pc_o, RST_PC);
      ram_dead = 1'b0;
      do_reset();

      // Randomized traffic
      noise_en  = 1'b1;
      lat_force = -1;
      repeat (150) begin
         if (m_fault) fault_checks();
         case ($urandom_range(0, 3))
            0: do_update(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_target());
            1, 2: do_fetch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), rand_target(), 1);
            default: begin
               tick();
               check_state();
            end
         endcase
      end
      tick();
      chk("scoreboard drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
